avalon_slave_mem: RTL and testbench
===================================

// Module: avalon_slave_mem
// PURPOSE
//  Avalon-MM slave (responder) word memory with fixed, programmable wait states.
//  It answers the CPU bus master's read/write requests and drives waitrequest.
//  Serves as the instruction/data memory model for CPU testbenches and FPGA bring-up.
//  Address window is byte-addressed, word-aligned, based at BASE_ADDR.
// PARAMETERS
//  ADDR_WIDTH   12            word-index bits; depth = 2**ADDR_WIDTH words
//  BASE_ADDR    32'hBFC00000  byte address of word 0
//  WAIT_CYCLES  2             waitrequest-high cycles per transfer; legal range 1..15
//  INIT_FILE    ""            $readmemh hex image; empty string = no preload
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  address      in   32  byte address from master
//  read         in   1   read request
//  write        in   1   write request
//  waitrequest  out  1   1 = master must hold request stable
//  writedata    in   32  write data
//  byteenable   in   4   write byte lanes; bit i enables writedata[8i+7:8i]
//  readdata     out  32  read data, valid in the cycle where waitrequest=0 and read=1
//  err          out  1   sticky protocol/decode error flag, cleared only by reset
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, cnt=0, readdata=0, err=0. Memory array is NOT cleared.
//  waitrequest = (read|write) & (state!=READY); it is combinational, 0 when idle.
//  FSM: IDLE -> WAIT -> READY -> IDLE.
//   IDLE: request seen in cycle T -> latch address/read/write, cnt<=WAIT_CYCLES-1.
//         If WAIT_CYCLES==1, go straight to READY; otherwise go to WAIT.
//   WAIT: cnt decrements each cycle; go to READY when cnt==1.
//   READY: waitrequest=0, which is cycle T+WAIT_CYCLES.
//         A read drives readdata from the registered array word in this cycle.
//         A write commits the enabled bytes at the clock edge ending READY.
//         The next state is always IDLE. A request held into T+WAIT_CYCLES+1 is a new transfer.
//  Protocol errors. Each sets err<=1, aborts the transfer (next state IDLE) and leaves memory unchanged:
//   read&write asserted together.
//   address[1:0]!=0.
//   address outside [BASE_ADDR, BASE_ADDR+4*depth-1]. A read in this case completes with readdata=0.
//   address/read/write changed while in WAIT.
//  Word index = (address-BASE_ADDR)>>2, with ADDR_WIDTH bits.
//  A write with byteenable=0 completes normally and writes nothing.
//  byteenable is ignored on reads; the full word is returned.
//  Reset asserted mid-transfer: the transfer is dropped and no write occurs.
//  readdata holds its last value outside READY.
// CONFIGURATION
//  `AV_SLAVE_RANDOM_WAIT_EN defined: adds 0..3 extra wait cycles per transfer.
//   The extra count is taken from lfsr[1:0] when the request is accepted.
//   The LFSR is 16-bit, seed 16'hACE1 at reset, and steps once per accepted request.
//   This exercises master stall handling.
//  Undefined: latency is exactly WAIT_CYCLES; no LFSR logic is built.
// STRUCTURE
//  avalon_pkg holds:
//   the state enum typedef av_slv_state_t {IDLE, WAIT, READY};
//   the constant AV_WORD_BYTES=4;
//   the function be_mask(byteenable), which returns a 32-bit lane mask.
//  Optional sub-module lfsr16 (clk, reset, step, q[15:0]), instantiated only under the macro.
//  The memory is a single inferred array: logic [31:0] mem [2**ADDR_WIDTH].
// TESTING
//  Default parameters, macro off, unless stated.
//  1 Write then read:
//    write 0xBFC00000 <= 0xDEADBEEF, be=4'hF -> waitrequest high 2 cycles, low at cycle 3.
//    Read back the same address -> readdata=0xDEADBEEF with waitrequest=0.
//  2 Partial write:
//    write 0x11223344 to 0xBFC00004 with be=4'b0101 over prior 0xFFFFFFFF.
//    Read back -> 0xFF22FF44.
//  3 Errors:
//    address 0xBFC00002 -> err=1 after that transfer, memory unchanged.
//    read=write=1 -> err=1.
//    Read at 0x00000000 -> readdata=0, err=1.
//  4 Back-to-back: read held high across 3 consecutive transfers.
//    -> waitrequest pattern 1,1,0 repeated, each readdata correct.
//  5 Reset mid-WAIT: reset=0 during the 2nd wait cycle of a write of 0x12345678.
//    -> waitrequest returns low when idle, err=0, and the target word keeps its old value.
//  6 WAIT_CYCLES=1: read -> 1 waitrequest cycle, data in cycle 2.
//    With the macro on: latency is in 1..4 and data stays correct over 100 random transfers.

Source files
------------

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pkg
// Purpose  : Shared types, constants and helpers for the Avalon-MM slave
//            memory. Provides the FSM state type, the bus word size in bytes
//            and the byte-enable to bit-mask expansion.
// Revision : 1.0 - initial release
// ============================================================================
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } av_slv_state_t;

  localparam int AV_WORD_BYTES = 4;

  // Expand a 4-bit byteenable into a 32-bit mask with 8 bits per lane.
  function automatic logic [31:0] be_mask(input logic [AV_WORD_BYTES-1:0] byteenable);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < AV_WORD_BYTES; i++) begin
      m[8*i +: 8] = {8{byteenable[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Galois LFSR (taps 16,14,13,11), seeded with 16'hACE1.
//            Advances one step in each cycle where step is high.
// Ports    : clk   in  1   rising-edge clock
//            reset in  1   asynchronous active-low reset
//            step  in  1   advance the sequence by one state
//            q     out 16  current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);

  localparam logic [15:0] c_SEED = 16'hACE1;
  localparam logic [15:0] c_TAPS = 16'hB400;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= c_SEED;
    end else if (step) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? c_TAPS : 16'h0000);
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : avalon_slave_mem
// Purpose  : Avalon-MM slave word memory with fixed, programmable wait states.
//            Byte-addressed, word-aligned window starting at BASE_ADDR.
//            Decode/protocol errors raise a sticky err flag and leave the
//            memory untouched.
// Ports    : clk         in  1   rising-edge clock
//            reset       in  1   asynchronous active-low reset
//            address     in  32  byte address from master
//            read        in  1   read request
//            write       in  1   write request
//            waitrequest out 1   master must hold the request while high
//            writedata   in  32  write data
//            byteenable  in  4   write byte lanes
//            readdata    out 32  read data, valid when waitrequest=0 & read=1
//            err         out 1   sticky error flag, cleared only by reset
// Config   : `AV_SLAVE_RANDOM_WAIT_EN adds 0..3 LFSR-chosen extra wait
//            cycles per transfer; undefined gives exactly WAIT_CYCLES.
// Notes    : INIT_FILE is kept for interface compatibility; the array is not
//            preloaded by this module and is never cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_slave_mem
  import avalon_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int c_DEPTH = 2**ADDR_WIDTH;

  logic [31:0] mem [c_DEPTH];

  av_slv_state_t         r_state;
  av_slv_state_t         w_next_state;
  logic [4:0]            r_cnt;
  logic [31:0]           r_addr;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_idx;

  logic                  w_req;
  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_decode_err;
  logic                  w_changed;
  logic [1:0]            w_extra;
  logic [4:0]            w_load_cnt;
  logic                  w_accept;
  logic                  w_set_err;
  logic                  w_rd_load;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_oor_read;
  logic [31:0]           w_be_mask;

  assign w_req = read | write;

  // Subtracting the base lets one unsigned compare cover both window edges:
  // addresses below BASE_ADDR wrap to large offsets. BASE_ADDR is word
  // aligned, so the low offset bits equal the low address bits.
  assign w_offset     = address - BASE_ADDR;
  assign w_in_range   = (w_offset[31:ADDR_WIDTH+2] == '0);
  assign w_idx        = w_offset[ADDR_WIDTH+1:2];
  assign w_decode_err = (read & write) | (w_offset[1:0] != 2'b00) | ~w_in_range;
  assign w_changed    = (address != r_addr) | (read != r_rd) | (write != r_wr);

`ifdef AV_SLAVE_RANDOM_WAIT_EN
  logic [15:0] w_lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (w_accept),
    .q     (w_lfsr_q)
  );

  assign w_extra = w_lfsr_q[1:0];
`else
  assign w_extra = 2'd0;
`endif

  assign w_load_cnt = 5'(WAIT_CYCLES - 1) + {3'b000, w_extra};

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_decode_err) begin
            w_set_err = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = (w_load_cnt == 5'd0) ? READY : WAIT;
          end
        end
      end
      WAIT: begin
        if (w_changed) begin
          w_set_err    = 1'b1;
          w_next_state = IDLE;
        end else if (r_cnt == 5'd1) begin
          w_next_state = READY;
        end
      end
      READY:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // readdata is loaded on the edge entering READY so it is already valid in
  // the cycle where waitrequest drops. Coming straight from IDLE the live
  // inputs still select the word; from WAIT the latched index does.
  assign w_rd_load  = (w_next_state == READY) && ((r_state == IDLE) ? read : r_rd);
  assign w_rd_idx   = (r_state == IDLE) ? w_idx : r_idx;
  assign w_oor_read = (r_state == IDLE) && read && !write && !w_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_idx    <= '0;
      readdata <= '0;
      err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= address;
        r_rd   <= read;
        r_wr   <= write;
        r_idx  <= w_idx;
        r_cnt  <= w_load_cnt;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 5'd1;
      end

      if (w_set_err) begin
        err <= 1'b1;
      end

      if (w_rd_load) begin
        readdata <= mem[w_rd_idx];
      end else if (w_oor_read) begin
        readdata <= '0;
      end
    end
  end

  // Memory array: no reset so it survives reset. The reset term blocks a
  // commit on an edge where reset is already low.
  assign w_be_mask = be_mask(byteenable);

  always_ff @(posedge clk) begin
    if (reset && (r_state == READY) && r_wr) begin
      mem[r_idx] <= (mem[r_idx] & ~w_be_mask) | (writedata & w_be_mask);
    end
  end

  assign waitrequest = w_req & (r_state != READY);

endmodule
`default_nettype wire

// File: tb/tb_avalon_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_slave_mem
// Purpose  : Self-checking bench for avalon_slave_mem. Instance 0 uses
//            WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=1. Directed cases
//            plus randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_slave_mem;

  localparam int          WC0  = 2;
  localparam int          WC1  = 1;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rdata;
  logic [1:0][3:0]  be;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0]       wreq;
  logic [1:0]       errf;

  avalon_slave_mem #(.WAIT_CYCLES(WC0)) u_dut0 (
    .clk(clk), .reset(rst_n), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .waitrequest(wreq[0]), .writedata(wdata[0]), .byteenable(be[0]),
    .readdata(rdata[0]), .err(errf[0])
  );

  avalon_slave_mem #(.WAIT_CYCLES(WC1)) u_dut1 (
    .clk(clk), .reset(rst_n), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .waitrequest(wreq[1]), .writedata(wdata[1]), .byteenable(be[1]),
    .readdata(rdata[1]), .err(errf[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: 16 words per instance starting at BASE.
  logic [31:0] ref_mem [2][16];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int wc_of(input int s);
    return (s == 0) ? WC0 : WC1;
  endfunction

  // lat counts cycles from the request up to and including the cycle with
  // waitrequest low, so waitrequest was high for lat-1 cycles.
  task automatic check_lat(input string tag, input int s, input int lat);
`ifdef AV_SLAVE_RANDOM_WAIT_EN
    check_eq(tag, 32'((lat >= wc_of(s) + 1) && (lat <= wc_of(s) + 4)), 32'd1);
`else
    check_eq(tag, 32'(lat), 32'(wc_of(s) + 1));
`endif
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the completing cycle.
  task automatic xfer(input int s, input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input bit hold, output int lat, output logic [31:0] q);
    addr[s]  = a;
    wdata[s] = d;
    be[s]    = b;
    rd[s]    = !is_wr;
    wr[s]    = is_wr;
    lat = 1;
    #1;
    while (wreq[s] === 1'b1 && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (wreq[s] !== 1'b0) check_eq($sformatf("timeout_dut%0d", s), {31'b0, wreq[s]}, 32'd0);
    q = rdata[s];
    @(negedge clk);
    if (!hold) begin
      rd[s] = 1'b0;
      wr[s] = 1'b0;
    end
  endtask

  task automatic mwrite(input int s, input int idx, input logic [31:0] d, input logic [3:0] b,
                        input string tag);
    int          lat;
    logic [31:0] q;
    xfer(s, 1'b1, BASE + 32'(idx * 4), d, b, 1'b0, lat, q);
    check_lat({tag, "_lat"}, s, lat);
    ref_mem[s][idx] = merge(ref_mem[s][idx], d, b);
  endtask

  task automatic mread(input int s, input int idx, input bit hold, input string tag);
    int          lat;
    logic [31:0] q;
    xfer(s, 1'b0, BASE + 32'(idx * 4), 32'h0, 4'h0, hold, lat, q);
    check_lat({tag, "_lat"}, s, lat);
    check_eq({tag, "_data"}, q, ref_mem[s][idx]);
  endtask

  // Single-cycle request that the slave rejects at decode.
  task automatic pulse(input int s, input bit r, input bit w, input logic [31:0] a);
    addr[s]  = a;
    wdata[s] = 32'hA5A5A5A5;
    be[s]    = 4'hF;
    rd[s]    = r;
    wr[s]    = w;
    @(negedge clk);
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;

    rst_n = 1'b0;
    addr  = '0; wdata = '0; be = '0; rd = '0; wr = '0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) ref_mem[s][i] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_waitrequest", {31'b0, wreq[0]}, 32'd0);
    check_eq("rst_err",         {31'b0, errf[0]}, 32'd0);
    check_eq("rst_readdata",    rdata[0],         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back
    mwrite(0, 0, 32'hDEADBEEF, 4'hF, "t1_wr");
    xfer(0, 1'b0, BASE, 32'h0, 4'h0, 1'b0, lat, q);
    check_lat("t1_rd_lat", 0, lat);
    check_eq("t1_rd_data", q, 32'hDEADBEEF);

    // Partial write over all-ones
    mwrite(0, 1, 32'hFFFFFFFF, 4'hF, "t2_fill");
    mwrite(0, 1, 32'h11223344, 4'b0101, "t2_part");
    xfer(0, 1'b0, BASE + 32'd4, 32'h0, 4'hF, 1'b0, lat, q);
    check_eq("t2_rd_data", q, 32'hFF22FF44);

    // Back-to-back reads with read held high throughout
    for (int i = 2; i < 5; i++) mwrite(0, i, $urandom, 4'hF, "t4_fill");
    mread(0, 2, 1'b1, "t4_b2b0");
    mread(0, 3, 1'b1, "t4_b2b1");
    mread(0, 4, 1'b0, "t4_b2b2");
    check_eq("t4_err_clear", {31'b0, errf[0]}, 32'd0);

    // Errors: misaligned write leaves memory intact
    pulse(0, 1'b0, 1'b1, BASE + 32'd2);
    check_eq("t3_misalign_err", {31'b0, errf[0]}, 32'd1);
    mread(0, 0, 1'b0, "t3_misalign_mem");
    do_reset();
    check_eq("t3_reset_err", {31'b0, errf[0]}, 32'd0);
    pulse(0, 1'b1, 1'b1, BASE + 32'd8);
    check_eq("t3_rdwr_err", {31'b0, errf[0]}, 32'd1);
    do_reset();
    mread(0, 0, 1'b0, "t3_pre_oor");
    pulse(0, 1'b1, 1'b0, 32'h00000000);
    check_eq("t3_oor_readdata", rdata[0], 32'd0);
    check_eq("t3_oor_err", {31'b0, errf[0]}, 32'd1);
    do_reset();
    // Address changed while waiting
    addr[0] = BASE; rd[0] = 1'b1; be[0] = 4'hF;
    @(negedge clk);
    addr[0] = BASE + 32'd4;
    @(negedge clk);
    rd[0] = 1'b0;
    @(negedge clk);
    check_eq("t3_change_err", {31'b0, errf[0]}, 32'd1);
    do_reset();

    // Reset during the second wait cycle of a write
    addr[0] = BASE + 32'd4; wdata[0] = 32'h12345678; be[0] = 4'hF; wr[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    wr[0] = 1'b0;
    #1;
    check_eq("t5_waitreq_idle", {31'b0, wreq[0]}, 32'd0);
    check_eq("t5_err", {31'b0, errf[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, BASE + 32'd4, 32'h0, 4'h0, 1'b0, lat, q);
    check_eq("t5_old_value", q, 32'hFF22FF44);

    // Single wait cycle instance
    mwrite(1, 0, 32'hCAFEF00D, 4'hF, "t6_wr");
    xfer(1, 1'b0, BASE, 32'h0, 4'h0, 1'b0, lat, q);
    check_lat("t6_rd_lat", 1, lat);
    check_eq("t6_rd_data", q, 32'hCAFEF00D);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mwrite(s, i, $urandom, 4'hF, "rnd_init");
      for (int n = 0; n < 100; n++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1)
          mwrite(s, idx, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d_wr", s));
        else
          mread(s, idx, 1'b0, $sformatf("rnd%0d_rd", s));
      end
      check_eq($sformatf("rnd%0d_err", s), {31'b0, errf[s]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
